// File: rtl/if_prefetch_stage_if.sv
// if_prefetch_stage_if: decoupled request/response instruction memory port.
interface if_prefetch_stage_if #(parameter int XLEN = 32);
  logic            Mem_req_valid;
  logic [XLEN-1:0] Mem_req_addr;
  logic            Mem_req_ready;
  logic            Mem_rsp_valid;
  logic [XLEN-1:0] Mem_rsp_data;
  modport master (output Mem_req_valid, Mem_req_addr, input Mem_req_ready, Mem_rsp_valid, Mem_rsp_data);
  modport slave  (input Mem_req_valid, Mem_req_addr, output Mem_req_ready, Mem_rsp_valid, Mem_rsp_data);
endinterface

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: fetch stage with DEPTH-entry prefetch queue; define IF_TRACKER_EN to add the IF_tracker output.
module if_prefetch_stage #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  if_prefetch_stage_if.master    mem,
  input  logic                   Redirect_valid,
  input  logic [XLEN-1:0]        Redirect_target,
  input  logic                   Stall,
  output logic [XLEN-1:0]        Instruction_o,
  output logic [XLEN-1:0]        Program_counter,
  output logic                   Inst_valid_o,
  output logic [$clog2(DEPTH):0] Queue_count
`ifdef IF_TRACKER_EN
  ,
  output logic [7:0]             IF_tracker
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] q_pc [DEPTH];
  logic [XLEN-1:0] q_inst [DEPTH];
  logic [XLEN-1:0] tag_pc [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CW-1:0] inflight, drop;
  logic [CW:0] credit;
  logic accept, rsp, rsp_drop, push, pop;
  assign credit = {1'b0, Queue_count} + {1'b0, inflight};
  assign mem.Mem_req_valid = Reset_n && !Redirect_valid && (credit < (CW+1)'(DEPTH));
  assign mem.Mem_req_addr = fetch_pc;
  assign accept = mem.Mem_req_valid && mem.Mem_req_ready;
  assign rsp = mem.Mem_rsp_valid;
  assign rsp_drop = drop != '0;
  assign push = rsp && !rsp_drop && !Redirect_valid;
  assign pop = !Redirect_valid && !Stall && Queue_count != '0;
  always_ff @(posedge Clk) begin
    if (accept) tag_pc[tag_wr] <= fetch_pc;
    if (push) begin
      q_pc[wr_ptr] <= tag_pc[tag_rd];
      q_inst[wr_ptr] <= mem.Mem_rsp_data;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fetch_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      tag_rd <= '0;
      tag_wr <= '0;
      Queue_count <= '0;
      inflight <= '0;
      drop <= '0;
      Instruction_o <= NOP_INST;
      Program_counter <= '0;
      Inst_valid_o <= 1'b0;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        tag_wr <= tag_wr + 1'b1;
      end
      if (rsp) tag_rd <= tag_rd + 1'b1;
      inflight <= inflight + CW'(accept) - CW'(rsp);
      if (Redirect_valid) begin
        fetch_pc <= Redirect_target & ~XLEN'(3);
        drop <= inflight - CW'(rsp);
        rd_ptr <= '0;
        wr_ptr <= '0;
        Queue_count <= '0;
        Instruction_o <= NOP_INST;
        Inst_valid_o <= 1'b0;
      end else begin
        drop <= drop - CW'(rsp && rsp_drop);
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        Queue_count <= Queue_count + CW'(push) - CW'(pop);
        if (!Stall) begin
          Instruction_o <= pop ? q_inst[rd_ptr] : NOP_INST;
          Program_counter <= pop ? q_pc[rd_ptr] : Program_counter;
          Inst_valid_o <= pop;
        end
      end
    end
  end
`ifdef IF_TRACKER_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) IF_tracker <= '0;
    else if (Redirect_valid) IF_tracker <= '0;
    else if (pop) IF_tracker <= IF_tracker + 8'd1;
  end
`endif
  // credit-based issue means a full queue can never see a push
  assert property (@(posedge Clk) disable iff (!Reset_n) !(push && Queue_count == CW'(DEPTH)));
endmodule
